// File: rtl/lcd_reader_if.sv
// Requester and LCD-pin bundle for lcd_reader.
// slave = the reader block, master = requester plus LCD pads.
interface lcd_reader_if;
    logic       req;
    logic       rs_sel;
    logic       ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [3:0] db_in;
    logic       sf_e;
    logic       e;
    logic       rs;
    logic       rw;
    logic       db_oe;

    modport slave (
        input  req, rs_sel, db_in,
        output ready, rd_valid, rd_data, sf_e, e, rs, rw, db_oe
    );

    modport master (
        output req, rs_sel, db_in,
        input  ready, rd_valid, rd_data, sf_e, e, rs, rw, db_oe
    );
endinterface

// File: rtl/lcd_reader.sv
// lcd_reader: HD44780 4-bit read sequencer; two E strobes return one byte {hi, lo}.
// Optional LCD_RD_POLL_EN: RS=0 reads repeat until the busy flag (hi[3]) reads 0.
module lcd_reader #(
    parameter int T_AS = 3,
    parameter int T_EH = 18,
    parameter int T_EL = 50
) (
    input logic         clk,
    input logic         rst_n,
    lcd_reader_if.slave bus
);
    localparam int TMAX = (T_AS > T_EH) ? ((T_AS > T_EL) ? T_AS : T_EL)
                                        : ((T_EH > T_EL) ? T_EH : T_EL);
    localparam int CW = $clog2(TMAX) + 1;
    localparam logic [CW-1:0] LD_AS = CW'(T_AS - 1);
    localparam logic [CW-1:0] LD_EH = CW'(T_EH - 1);
    localparam logic [CW-1:0] LD_EL = CW'(T_EL - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SETUP_H = 4'd1,
        EHIGH_H = 4'd2,
        ELOW_H  = 4'd3,
        SETUP_L = 4'd4,
        EHIGH_L = 4'd5,
        ELOW_L  = 4'd6,
        DONE    = 4'd7
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    db_meta_q;
    logic [3:0]    db_sync_q;
    logic [3:0]    hi_q;
    logic [3:0]    lo_q;
    logic [7:0]    rd_data_q;
    logic          ready_q;
    logic          rd_valid_q;
    logic          e_q;
    logic          rs_q;
    logic          cnt_done_s;
    logic          poll_again_s;

    assign cnt_done_s = (cnt_q == '0);

`ifdef LCD_RD_POLL_EN
    // rs_q still holds the captured select here, so it doubles as the RS=0 test.
    assign poll_again_s = (rs_q == 1'b0) && (hi_q[3] == 1'b1);
`else
    assign poll_again_s = 1'b0;
`endif

    // Two-flop synchronizer on the LCD data pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_meta_q <= 4'h0;
            db_sync_q <= 4'h0;
        end else begin
            db_meta_q <= bus.db_in;
            db_sync_q <= db_meta_q;
        end
    end

    // Read-cycle sequencer; every pin-facing output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= 4'h0;
            lo_q       <= 4'h0;
            rd_data_q  <= 8'h00;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            e_q        <= 1'b0;
            rs_q       <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        rs_q    <= bus.rs_sel;
                        ready_q <= 1'b0;
                        cnt_q   <= LD_AS;
                        state_q <= SETUP_H;
                    end
                end
                SETUP_H: begin
                    if (cnt_done_s) begin
                        e_q     <= 1'b1;
                        cnt_q   <= LD_EH;
                        state_q <= EHIGH_H;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                EHIGH_H: begin
                    if (cnt_done_s) begin
                        hi_q    <= db_sync_q;
                        e_q     <= 1'b0;
                        cnt_q   <= LD_EL;
                        state_q <= ELOW_H;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                ELOW_H: begin
                    if (cnt_done_s) begin
                        cnt_q   <= LD_AS;
                        state_q <= SETUP_L;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                SETUP_L: begin
                    if (cnt_done_s) begin
                        e_q     <= 1'b1;
                        cnt_q   <= LD_EH;
                        state_q <= EHIGH_L;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                EHIGH_L: begin
                    if (cnt_done_s) begin
                        lo_q    <= db_sync_q;
                        e_q     <= 1'b0;
                        cnt_q   <= LD_EL;
                        state_q <= ELOW_L;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                ELOW_L: begin
                    if (cnt_done_s) begin
                        if (poll_again_s) begin
                            cnt_q   <= LD_AS;
                            state_q <= SETUP_H;
                        end else begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= {hi_q, lo_q};
                            rs_q       <= 1'b0;
                            cnt_q      <= '0;
                            state_q    <= DONE;
                        end
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    e_q     <= 1'b0;
                    rs_q    <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.e        = e_q;
    assign bus.rs       = rs_q;
    assign bus.sf_e     = 1'b1;
    assign bus.rw       = 1'b1;
    assign bus.db_oe    = 1'b0;
endmodule

// File: tb/tb_lcd_reader.sv
// Bench for lcd_reader: cycle-timeline model of each read plus directed literal checks.
module tb_lcd_reader;
    localparam int T_AS = 3;
    localparam int T_EH = 18;
    localparam int T_EL = 50;
    localparam int HALF = T_AS + T_EH + T_EL;
    localparam int TOT  = 2 * HALF + 1;
`ifdef LCD_RD_POLL_EN
    localparam bit POLL = 1'b1;
`else
    localparam bit POLL = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    lcd_reader_if bus_if ();

    lcd_reader #(.T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    // Nibbles the fake LCD returns, one entry per complete read, in order.
    logic [3:0] hi_tab [0:9] = '{4'h4, 4'h2, 4'h5, 4'h3, 4'h6, 4'h1, 4'h8, 4'h8, 4'h8, 4'h0};
    logic [3:0] lo_tab [0:9] = '{4'h1, 4'h7, 4'hA, 4'hC, 4'h9, 4'hE, 4'h3, 4'h3, 4'h3, 4'h5};

    // Model: busy flag, cycle offset within the current read (1..TOT), read index.
    bit         m_busy = 1'b0;
    int         m_k    = 0;
    int         m_cur  = -1;
    bit         m_rs   = 1'b0;
    logic [7:0] m_data = 8'h00;
    bit         prev_req   = 1'b0;
    bit         prev_rs    = 1'b0;
    bit         prev_rstn  = 1'b0;
    int         e_run      = 0;

    assign bus_if.db_in = !m_busy ? 4'h0 :
                          (m_k <= HALF) ? hi_tab[(m_cur < 0) ? 0 : m_cur]
                                        : lo_tab[(m_cur < 0) ? 0 : m_cur];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance the model one cycle, then compare every DUT output to it.
    always @(negedge clk) begin
        bit         e_exp;
        bit         rs_exp;
        bit         v_exp;
        if (!rst_n || !prev_rstn) begin
            m_busy = 1'b0;
            m_k    = 0;
            m_data = 8'h00;
        end else if (m_busy) begin
            if (m_k == TOT) begin
                m_busy = 1'b0;
            end else if (m_k == 2 * HALF && POLL && !m_rs && hi_tab[m_cur][3]) begin
                m_k   = 1;
                m_cur = m_cur + 1;
            end else begin
                m_k = m_k + 1;
                if (m_k == TOT) m_data = {hi_tab[m_cur], lo_tab[m_cur]};
            end
        end else if (prev_req) begin
            m_busy = 1'b1;
            m_k    = 1;
            m_rs   = prev_rs;
            m_cur  = m_cur + 1;
        end

        e_exp  = m_busy && ((m_k > T_AS && m_k <= T_AS + T_EH) ||
                            (m_k > HALF + T_AS && m_k <= HALF + T_AS + T_EH));
        rs_exp = m_busy && (m_k <= 2 * HALF) && m_rs;
        v_exp  = m_busy && (m_k == TOT);

        chk("ready",    bus_if.ready,    !m_busy);
        chk("rd_valid", bus_if.rd_valid, v_exp);
        chk("rd_data",  bus_if.rd_data,  m_data);
        chk("e",        bus_if.e,        e_exp);
        chk("rs",       bus_if.rs,       rs_exp);
        chk("rw",       bus_if.rw,       1'b1);
        chk("sf_e",     bus_if.sf_e,     1'b1);
        chk("db_oe",    bus_if.db_oe,    1'b0);

        if (!rst_n) begin
            e_run = 0;
        end else if (bus_if.e === 1'b1) begin
            e_run = e_run + 1;
        end else begin
            if (e_run != 0) chk("e_width", e_run, 18);
            e_run = 0;
        end

        prev_req  = bus_if.req;
        prev_rs   = bus_if.rs_sel;
        prev_rstn = rst_n;
    end

    task automatic start_req(input bit rs);
        @(posedge clk); #2;
        bus_if.req    = 1'b1;
        bus_if.rs_sel = rs;
        @(posedge clk); #2;
        bus_if.req    = 1'b0;
    endtask

    task automatic wait_valid(input int start, input int bound, input string name, output int n);
        bit got;
        got = 1'b0;
        n   = start;
        while (!got && n < bound) begin
            @(negedge clk);
            n++;
            if (bus_if.rd_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_chk++;
            $display("FAIL %s_timeout: got no rd_valid expected one within %0d cycles", name, bound);
        end
    endtask

    initial begin
        int  n;
        bit  found;
        bus_if.req    = 1'b0;
        bus_if.rs_sel = 1'b0;

        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready",   bus_if.ready,   1'b1);
        chk("rst_e",       bus_if.e,       1'b0);
        chk("rst_rw",      bus_if.rw,      1'b1);
        chk("rst_sf_e",    bus_if.sf_e,    1'b1);
        chk("rst_db_oe",   bus_if.db_oe,   1'b0);
        chk("rst_rd_data", bus_if.rd_data, 8'h00);

        start_req(1'b1);
        wait_valid(0, 400, "data", n);
        chk("data_lat",  n, 143);
        chk("data_byte", bus_if.rd_data, 8'h41);

        // Extra req pulse mid-transaction must be ignored.
        start_req(1'b0);
        repeat (40) @(posedge clk);
        #2 bus_if.req = 1'b1;
        @(posedge clk);
        #2 bus_if.req = 1'b0;
        wait_valid(41, 400, "midreq", n);
        chk("midreq_lat",  n, 143);
        chk("midreq_byte", bus_if.rd_data, 8'h27);

        // req held high: second read is accepted on the first ready cycle.
        @(posedge clk); #2;
        bus_if.req    = 1'b1;
        bus_if.rs_sel = 1'b1;
        @(posedge clk); #2;
        bus_if.rs_sel = 1'b0;
        wait_valid(0, 400, "held1", n);
        chk("held1_lat",  n, 143);
        chk("held1_byte", bus_if.rd_data, 8'h5A);
        @(posedge clk);
        @(posedge clk); #2;
        bus_if.req = 1'b0;
        wait_valid(0, 400, "held2", n);
        chk("held2_lat",  n, 143);
        chk("held2_byte", bus_if.rd_data, 8'h3C);

        // Reset pulse in the middle of the second E strobe.
        start_req(1'b1);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            if (m_busy && m_k == 80) found = 1'b1;
        end
        chk("mid_found", found, 1'b1);
        #3;
        chk("mid_e_high", bus_if.e, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_e",       bus_if.e,       1'b0);
        chk("async_ready",   bus_if.ready,   1'b1);
        chk("async_rs",      bus_if.rs,      1'b0);
        chk("async_rd_data", bus_if.rd_data, 8'h00);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        start_req(1'b0);
        wait_valid(0, 400, "post_rst", n);
        chk("post_rst_lat",  n, 143);
        chk("post_rst_byte", bus_if.rd_data, 8'h1E);

        // Busy-flag read: BF=1 on three reads, then 0x0/0x5.
        start_req(1'b0);
        wait_valid(0, 1200, "bf", n);
`ifdef LCD_RD_POLL_EN
        chk("poll_lat",  n, 569);
        chk("poll_byte", bus_if.rd_data, 8'h05);
`else
        chk("bf_lat",  n, 143);
        chk("bf_byte", bus_if.rd_data, 8'h83);
        chk("bf_flag", bus_if.rd_data[7], 1'b1);
`endif

        repeat (4) @(negedge clk);
        chk("end_ready", bus_if.ready, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
